// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two half adders + OR)
// is reused over WIDTH cycles, LSB first, behind a start/busy/done handshake.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Shared full-adder cell built from two half adders
    logic ha0_s, ha0_c, fa_s, ha1_c, fa_co;

    half_adder u_ha0 (
        .a (a_sh_q[0]),
        .b (b_sh_q[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder u_ha1 (
        .a (ha0_s),
        .b (carry_q),
        .s (fa_s),
        .c (ha1_c)
    );

    assign fa_co = ha0_c | ha1_c;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    acc_d   = {WIDTH{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last bit: publish result including this cycle's sum bit
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags follow the next state so they are flop outputs
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=4.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, start4 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00, sum8;
    logic [3:0] a4 = 4'h0, b4 = 4'h0, sum4;
    logic       busy8, done8, cout8, busy4, done4, cout4;

    int checks = 0;
    int failures = 0;
    logic [31:0] prev_s [2];
    logic        prev_c [2];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8), .CNT_W(5)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic        busy_of(input bit w4); return w4 ? busy4 : busy8; endfunction
    function automatic logic        done_of(input bit w4); return w4 ? done4 : done8; endfunction
    function automatic logic        cout_of(input bit w4); return w4 ? cout4 : cout8; endfunction
    function automatic logic [31:0] sum_of (input bit w4); return w4 ? {28'd0, sum4} : {24'd0, sum8}; endfunction

    // Reference: plain unsigned addition truncated to w bits, carry = bit w
    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input int w);
        logic [32:0] full;
        logic [32:0] mask;
        full = {1'b0, x} + {1'b0, y};
        mask = (33'd1 << w) - 33'd1;
        return {full[w], (full[31:0] & mask[31:0])};
    endfunction

    // One complete add on the selected DUT, with latency and handshake checks
    task automatic run_add(input bit w4, input logic [31:0] av, input logic [31:0] bv,
                           output logic [31:0] s, output logic c);
        int    w;
        int    lat;
        string tag;
        w   = w4 ? 4 : 8;
        tag = w4 ? "w4" : "w8";
        @(negedge clk);
        if (w4) begin start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; end
        else    begin start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; end
        @(negedge clk);
        start4 = 1'b0; start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
        check({tag, " busy_after_accept"}, {31'd0, busy_of(w4)}, 32'd1);
        check({tag, " sum_hold_in_run"}, sum_of(w4), prev_s[w4]);
        lat = 0;
        while (!done_of(w4) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " done_latency"}, lat, w);
        s = sum_of(w4);
        c = cout_of(w4);
        prev_s[w4] = s;
        prev_c[w4] = c;
        @(negedge clk);
        check({tag, " done_one_cycle"}, {31'd0, done_of(w4)}, 32'd0);
        check({tag, " idle_after_done"}, {31'd0, busy_of(w4)}, 32'd0);
    endtask

    vec_t vecs [7];

    initial begin
        logic [31:0] s;
        logic        c;
        logic [32:0] r;
        int          pulses;
        int          pos [$];
        logic [31:0] ra, rb;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
        vecs[3] = '{8'h0F, 8'h01, 8'h10, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        prev_s[0] = 32'd0; prev_s[1] = 32'd0;
        prev_c[0] = 1'b0;  prev_c[1] = 1'b0;

        // Reset state
        #12;
        check("reset busy8", {31'd0, busy8}, 32'd0);
        check("reset done8", {31'd0, done8}, 32'd0);
        check("reset sum8", {24'd0, sum8}, 32'd0);
        check("reset cout8", {31'd0, cout8}, 32'd0);
        check("reset busy4", {31'd0, busy4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of directed WIDTH=8 vectors
        for (int i = 0; i < 7; i++) begin
            run_add(1'b0, {24'd0, vecs[i].a}, {24'd0, vecs[i].b}, s, c);
            check($sformatf("vec%0d sum", i), s, {24'd0, vecs[i].exp_sum});
            check($sformatf("vec%0d cout", i), {31'd0, c}, {31'd0, vecs[i].exp_cout});
        end

        // start pulses in RUN (edge 3) and DONE (edge 9) are ignored
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A;
        @(negedge clk);
        pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            start8 = (k == 3 || k == 9);
            a8 = 8'h11; b8 = 8'h22;
            @(negedge clk);
            if (done8) begin
                pulses++;
                check("ignore_start sum", {24'd0, sum8}, 32'h0000_00FF);
                check("ignore_start cout", {31'd0, cout8}, 32'd0);
            end
        end
        start8 = 1'b0;
        check("ignore_start pulses", pulses, 1);
        check("ignore_start idle", {31'd0, busy8}, 32'd0);
        check("ignore_start sum_held", {24'd0, sum8}, 32'h0000_00FF);

        // start held high: one add every WIDTH+2 cycles
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done8) begin
                pos.push_back(k);
                check("hold_start sum", {24'd0, sum8}, 32'd0);
                check("hold_start cout", {31'd0, cout8}, 32'd1);
            end
        end
        start8 = 1'b0;
        check("hold_start pulses", pos.size(), 4);
        for (int i = 0; i < pos.size(); i++)
            check($sformatf("hold_start pos%0d", i), pos[i], 8 + 10 * i);
        for (int k = 0; k < 20 && busy8; k++) @(negedge clk);
        check("hold_start drained", {31'd0, busy8}, 32'd0);
        prev_s[0] = 32'd0; prev_c[0] = 1'b1;

        // Asynchronous reset in the middle of a RUN
        start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset busy_before", {31'd0, busy8}, 32'd1);
        check("midreset cout_before", {31'd0, cout8}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy8}, 32'd0);
        check("midreset done", {31'd0, done8}, 32'd0);
        check("midreset sum", {24'd0, sum8}, 32'd0);
        check("midreset cout", {31'd0, cout8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_s[0] = 32'd0; prev_c[0] = 1'b0;
        prev_s[1] = 32'd0; prev_c[1] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8 || busy8) pulses++;
        end
        check("midreset no_done", pulses, 0);
        run_add(1'b0, 32'h0F, 32'h01, s, c);
        check("after_reset sum", s, 32'h10);
        check("after_reset cout", {31'd0, c}, 32'd0);

        // WIDTH=4 corner
        run_add(1'b1, 32'hF, 32'hF, s, c);
        check("w4 FF sum", s, 32'hE);
        check("w4 FF cout", {31'd0, c}, 32'd1);

        // Random pairs against the arithmetic model
        for (int i = 0; i < 200; i++) begin
            ra = {28'd0, 4'($urandom)};
            rb = {28'd0, 4'($urandom)};
            run_add(1'b1, ra, rb, s, c);
            r = ref_add(ra, rb, 4);
            check($sformatf("w4 rand%0d sum a=%0h b=%0h", i, ra, rb), s, r[31:0]);
            check($sformatf("w4 rand%0d cout", i), {31'd0, c}, {31'd0, r[32]});
        end
        for (int i = 0; i < 60; i++) begin
            ra = {24'd0, 8'($urandom)};
            rb = {24'd0, 8'($urandom)};
            run_add(1'b0, ra, rb, s, c);
            r = ref_add(ra, rb, 8);
            check($sformatf("w8 rand%0d sum a=%0h b=%0h", i, ra, rb), s, r[31:0]);
            check($sformatf("w8 rand%0d cout", i), {31'd0, c}, {31'd0, r[32]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
